// File: rtl/taxi_pkg.sv
// Shared types and tables for the taxi meter: trip states, speed steps,
// 7-segment patterns and a constant binary-to-BCD helper.
package taxi_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, STOP} state_t;

   localparam int unsigned ADD_W = 7;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // distance units per tick for speedup = 00/01/10/11
   localparam logic [2:0] STEP_TABLE [4] = '{3'd1, 3'd2, 3'd4, 3'd6};

   // {a,b,c,d,e,f,g,dp}, active low, dp off
   localparam logic [7:0] SEG_TABLE [16] = '{
      8'b0000_0011, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101,
      8'b1001_1001, 8'b0100_1001, 8'b0100_0001, 8'b0001_1111,
      8'b0000_0001, 8'b0000_1001, 8'b0001_0001, 8'b1100_0001,
      8'b0110_0011, 8'b1000_0101, 8'b0110_0001, 8'b0111_0001
   };

   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int unsigned i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_sat_add.sv
// N-digit BCD value plus a small binary addend; result sticks at all-9s
// and sat is raised when the true sum does not fit.
module bcd_sat_add
   import taxi_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic [4*DIGITS-1:0] a,
   input  logic [ADD_W-1:0]    addend,
   output logic [4*DIGITS-1:0] sum,
   output logic                sat
);

   logic [7:0]          carry;
   logic [7:0]          t;
   logic [4*DIGITS-1:0] raw;

   // binary addend rides in as the carry into the units digit
   always_comb begin
      carry = 8'(addend);
      t     = '0;
      raw   = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         t              = 8'(a[4*i +: 4]) + carry;
         raw[4*i +: 4]  = 4'(t % 8'd10);
         carry          = t / 8'd10;
      end
      sat = (carry != 8'd0);
      sum = sat ? {DIGITS{4'h9}} : raw;
   end

endmodule

// File: rtl/taxi_meter_core.sv
// Taxi fare meter: trip FSM, tick-driven distance/waiting accumulation in BCD
// with saturation, and a registered multiplexed 7-segment scan.
module taxi_meter_core
   import taxi_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 2000000,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned PRICE_DIGITS = 4,
   parameter int unsigned DIST_DIGITS  = 4,
   parameter int unsigned BASE_FARE    = 60,
   parameter int unsigned BASE_DIST    = 30,
   parameter int unsigned PER_DIST     = 2,
   parameter int unsigned WAIT_TICKS   = 60,
   parameter int unsigned WAIT_FARE    = 10
) (
   input  logic                      clk,
   input  logic                      CLR,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      pause,
   input  logic                      waiting,
   input  logic [1:0]                speedup,
   output logic [4*PRICE_DIGITS-1:0] price_bcd,
   output logic [4*DIST_DIGITS-1:0]  dist_bcd,
   output logic [2:0]                which,
   output logic [7:0]                seg,
   output logic                      enable,
   output logic                      ovf
);

   localparam int unsigned NDIG = PRICE_DIGITS + DIST_DIGITS;
   localparam int unsigned TW   = $clog2(TICK_DIV + 1);
   localparam int unsigned SW   = $clog2(SCAN_DIV + 1);
   localparam int unsigned WW   = $clog2(WAIT_TICKS + 1);
   localparam int unsigned BW   = $clog2(BASE_DIST + 8);
   localparam logic [31:0] BASE_FARE_BCD = to_bcd(BASE_FARE);

   state_t                    state;
   logic                      start_q;
   logic                      start_rise;
   logic                      tick;
   logic                      wait_wrap;
   logic [TW-1:0]             tick_cnt;
   logic [SW-1:0]             scan_cnt;
   logic [WW-1:0]             wait_cnt;
   logic [BW-1:0]             base_cnt;
   logic [BW-1:0]             base_room;
   logic [BW-1:0]             base_nxt;
   logic [2:0]                step;
   logic [2:0]                over;
   logic [ADD_W-1:0]          price_add;
   logic [ADD_W-1:0]          dist_add;
   logic [4*PRICE_DIGITS-1:0] price_sum;
   logic [4*DIST_DIGITS-1:0]  dist_sum;
   logic                      price_sat;
   logic                      dist_sat;
   logic [3:0]                digit;
   logic                      dp_on;

   assign start_rise = start & ~start_q;
   assign tick       = (state == RUN) && (tick_cnt == TW'(TICK_DIV - 1));
   assign wait_wrap  = (wait_cnt == WW'(WAIT_TICKS - 1));

   // base_cnt tracks units still covered by the base fare; only the part
   // of a step beyond it is charged
   always_comb begin
      step      = STEP_TABLE[speedup];
      base_room = BW'(BASE_DIST) - base_cnt;
      base_nxt  = base_cnt;
      over      = '0;
      if (BW'(step) <= base_room) begin
         base_nxt = base_cnt + BW'(step);
      end else begin
         base_nxt = BW'(BASE_DIST);
         over     = 3'(BW'(step) - base_room);
      end
      if (waiting) begin
         dist_add  = '0;
         price_add = wait_wrap ? ADD_W'(WAIT_FARE) : '0;
      end else begin
         dist_add  = ADD_W'(step);
         price_add = ADD_W'(over) * ADD_W'(PER_DIST);
      end
   end

   bcd_sat_add #(.DIGITS(PRICE_DIGITS)) u_price_add (
      .a      (price_bcd),
      .addend (price_add),
      .sum    (price_sum),
      .sat    (price_sat)
   );

   bcd_sat_add #(.DIGITS(DIST_DIGITS)) u_dist_add (
      .a      (dist_bcd),
      .addend (dist_add),
      .sum    (dist_sum),
      .sat    (dist_sat)
   );

   always_ff @(posedge clk) begin
      if (!CLR) begin
         state     <= IDLE;
         start_q   <= 1'b0;
         price_bcd <= '0;
         dist_bcd  <= '0;
         wait_cnt  <= '0;
         base_cnt  <= '0;
         tick_cnt  <= '0;
         enable    <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         start_q <= start;
         unique case (state)
            IDLE, STOP: begin
               if (start_rise) begin
                  state     <= RUN;
                  price_bcd <= BASE_FARE_BCD[4*PRICE_DIGITS-1:0];
                  dist_bcd  <= '0;
                  wait_cnt  <= '0;
                  base_cnt  <= '0;
                  tick_cnt  <= '0;
                  enable    <= 1'b1;
                  ovf       <= 1'b0;
               end
            end
            RUN: begin
               if (stop) begin
                  state  <= STOP;
                  enable <= 1'b0;
               end else begin
                  tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                  if (pause) begin
                     state  <= PAUSE;
                     enable <= 1'b0;
                  end
                  // a tick landing with pause still counts; saturation overrides PAUSE
                  if (tick) begin
                     price_bcd <= price_sum;
                     dist_bcd  <= dist_sum;
                     if (waiting) wait_cnt <= wait_wrap ? '0 : wait_cnt + 1'b1;
                     else         base_cnt <= base_nxt;
                     if (price_sat | dist_sat) begin
                        ovf    <= 1'b1;
                        state  <= STOP;
                        enable <= 1'b0;
                     end
                  end
               end
            end
            PAUSE: begin
               if (stop) begin
                  state <= STOP;
               end else if (!pause) begin
                  state  <= RUN;
                  enable <= ~ovf;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      digit = '0;
      for (int unsigned i = 0; i < PRICE_DIGITS; i++)
         if (which == 3'(i)) digit = price_bcd[4*(PRICE_DIGITS-1-i) +: 4];
      for (int unsigned i = 0; i < DIST_DIGITS; i++)
         if (which == 3'(PRICE_DIGITS + i)) digit = dist_bcd[4*(DIST_DIGITS-1-i) +: 4];
      dp_on = (which == 3'(PRICE_DIGITS - 2)) || (which == 3'(NDIG - 2));
   end

   always_ff @(posedge clk) begin
      if (!CLR) begin
         scan_cnt <= '0;
         which    <= '0;
         seg      <= SEG_BLANK;
      end else begin
         if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            which    <= (which == 3'(NDIG - 1)) ? '0 : which + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         if (state == IDLE)  seg <= SEG_BLANK;
         else if (dp_on)     seg <= SEG_TABLE[digit] & 8'hFE;
         else                seg <= SEG_TABLE[digit];
      end
   end

endmodule
